// File: rtl/score_pkg.sv
// Shared types and constants for the whack-an-engineer score tracker.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

  localparam int COMBO_W = 4;
  localparam logic [COMBO_W-1:0] COMBO_MAX = 4'd15;

endpackage

// File: rtl/score_tracker_if.sv
// Game-control, mole/hit input and score output bundle.
interface score_tracker_if #(
  parameter int N_MOLES = 3,
  parameter int SCORE_W = 8
);

  logic               gameStart;
  logic               gameEnd;
  logic [N_MOLES-1:0] moleUp;
  logic [N_MOLES-1:0] hit;
  logic [SCORE_W-1:0] score;
  logic [3:0]         combo;
  logic               doubleOn;
  logic               playing;
  logic [SCORE_W-1:0] highScore;

  modport master (
    output gameStart, gameEnd, moleUp, hit,
    input  score, combo, doubleOn, playing,
    input  highScore
  );

  modport slave (
    input  gameStart, gameEnd, moleUp, hit,
    output score, combo, doubleOn, playing,
    output highScore
  );

endinterface

// File: rtl/score_tracker_hit_classifier.sv
// Splits whack strobes into good (mole up) and bad (mole down) counts.
module hit_classifier #(
  parameter int N_MOLES = 3,
  parameter int CW      = $clog2(N_MOLES + 1)
) (
  input  logic [N_MOLES-1:0] hit,
  input  logic [N_MOLES-1:0] moleUp,
  output logic [CW-1:0]      good,
  output logic [CW-1:0]      bad
);

  always_comb begin
    good = '0;
    bad  = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      good = good + CW'(hit[i] & moleUp[i]);
      bad  = bad + CW'(hit[i] & ~moleUp[i]);
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Round FSM, saturating score, combo multiplier, optional high score.
// SCORE_TRACKER_HISCORE_EN builds the high-score register.
module score_tracker
  import score_pkg::*;
#(
  parameter int N_MOLES   = 3,
  parameter int SCORE_W   = 8,
  parameter int HIT_PTS   = 1,
  parameter int MISS_PTS  = 1,
  parameter int COMBO_LEN = 4
) (
  input logic           clock,
  input logic           scoreReset,
  score_tracker_if.slave bus
);

  localparam int CW = $clog2(N_MOLES + 1);
  localparam int NW = SCORE_W + 5;
  localparam logic signed [NW-1:0] SMAX =
    $signed({5'b0, {SCORE_W{1'b1}}});

  logic [CW-1:0]      good;
  logic [CW-1:0]      bad;
  state_t             state;
  logic [SCORE_W-1:0] score_q;
  logic [COMBO_W-1:0] combo_q;
  logic               dbl_q;
  logic               play_q;

  logic [NW-1:0]        gain;
  logic [NW-1:0]        loss;
  logic signed [NW-1:0] sum;
  logic [SCORE_W-1:0]   score_nx;
  logic [COMBO_W-1:0]   combo_nx;
  logic                 dbl_nx;

  hit_classifier #(
    .N_MOLES(N_MOLES)
  ) u_cls (
    .hit   (bus.hit),
    .moleUp(bus.moleUp),
    .good  (good),
    .bad   (bad)
  );

  always_comb begin
    gain = NW'(good) * NW'(HIT_PTS);
    if (dbl_q)
      gain = gain << 1;
    loss = NW'(bad) * NW'(MISS_PTS);
    sum  = $signed({5'b0, score_q})
         + $signed(gain) - $signed(loss);
    score_nx = score_q;
    if (sum < 0)
      score_nx = '0;
    else if (sum > SMAX)
      score_nx = '1;
    else
      score_nx = sum[SCORE_W-1:0];
  end

  // A miss breaks the streak even if a good hit lands alongside it.
  always_comb begin
    combo_nx = combo_q;
    if (bad != '0)
      combo_nx = '0;
    else if (good != '0 && combo_q != COMBO_MAX)
      combo_nx = combo_q + 1'b1;
    dbl_nx = int'(combo_nx) >= COMBO_LEN;
  end

  always_ff @(posedge clock or posedge scoreReset) begin
    if (scoreReset) begin
      state   <= IDLE;
      score_q <= '0;
      combo_q <= '0;
      dbl_q   <= 1'b0;
      play_q  <= 1'b0;
    end else if (bus.gameStart) begin
      state   <= PLAY;
      score_q <= '0;
      combo_q <= '0;
      dbl_q   <= 1'b0;
      play_q  <= 1'b1;
    end else begin
      case (state)
        PLAY: begin
          score_q <= score_nx;
          combo_q <= combo_nx;
          dbl_q   <= dbl_nx;
          if (bus.gameEnd) begin
            state  <= OVER;
            play_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_TRACKER_HISCORE_EN
  logic [SCORE_W-1:0] hs_q;

  // Final score includes any hit landing with gameEnd.
  always_ff @(posedge clock or posedge scoreReset) begin
    if (scoreReset)
      hs_q <= '0;
    else if (state == PLAY && !bus.gameStart &&
             bus.gameEnd && score_nx > hs_q)
      hs_q <= score_nx;
  end

  assign bus.highScore = hs_q;
`else
  assign bus.highScore = '0;
`endif

  assign bus.score    = score_q;
  assign bus.combo    = combo_q;
  assign bus.doubleOn = dbl_q;
  assign bus.playing  = play_q;

endmodule

// File: tb/tb_score_tracker.sv
// Randomised and directed bench for score_tracker against a
// rule-level reference model.
module tb_score_tracker;

  localparam int N   = 3;
  localparam int SW  = 8;
  localparam int HP  = 1;
  localparam int MP  = 1;
  localparam int CL  = 4;
  localparam int MAXS = (1 << SW) - 1;

  localparam int ST_IDLE = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_OVER = 2;

  logic clock;
  logic scoreReset;

  score_tracker_if #(.N_MOLES(N), .SCORE_W(SW)) bus ();

  score_tracker #(
    .N_MOLES  (N),
    .SCORE_W  (SW),
    .HIT_PTS  (HP),
    .MISS_PTS (MP),
    .COMBO_LEN(CL)
  ) dut (
    .clock     (clock),
    .scoreReset(scoreReset),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests;
  int n_fail;

  int m_st;
  int m_score;
  int m_combo;
  int m_dbl;
  int m_hs;

  task automatic model_reset();
    m_st    = ST_IDLE;
    m_score = 0;
    m_combo = 0;
    m_dbl   = 0;
    m_hs    = 0;
  endtask

  task automatic model_step(
    input logic gs, input logic ge,
    input logic [N-1:0] mu, input logic [N-1:0] h
  );
    int g, b, v;
    if (gs) begin
      m_st    = ST_PLAY;
      m_score = 0;
      m_combo = 0;
      m_dbl   = 0;
    end else if (m_st == ST_PLAY) begin
      g = $countones(h & mu);
      b = $countones(h & ~mu);
      v = m_score + g * HP * (m_dbl ? 2 : 1) - b * MP;
      m_score = (v < 0) ? 0 : (v > MAXS) ? MAXS : v;
      if (b > 0)
        m_combo = 0;
      else if (g > 0 && m_combo < 15)
        m_combo = m_combo + 1;
      m_dbl = (m_combo >= CL) ? 1 : 0;
      if (ge) begin
        m_st = ST_OVER;
`ifdef SCORE_TRACKER_HISCORE_EN
        if (m_score > m_hs)
          m_hs = m_score;
`endif
      end
    end
  endtask

  task automatic step(
    input logic gs, input logic ge,
    input logic [N-1:0] mu, input logic [N-1:0] h
  );
    bus.gameStart = gs;
    bus.gameEnd   = ge;
    bus.moleUp    = mu;
    bus.hit       = h;
    @(posedge clock);
    #1;
    model_step(gs, ge, mu, h);
    bus.gameStart = 1'b0;
    bus.gameEnd   = 1'b0;
    bus.hit       = '0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.score, bus.combo, bus.doubleOn,
         bus.playing, bus.highScore} !== '0) begin
      n_fail++;
      $display("FAIL reset: got s=%0d c=%0d d=%0b p=%0b h=%0d want all 0",
               bus.score, bus.combo, bus.doubleOn,
               bus.playing, bus.highScore);
    end
    step(1'b1, 1'b0, 3'b001, 3'b001);
    n_tests++;
    if (bus.playing !== 1'b1 || bus.score !== 8'd0) begin
      n_fail++;
      $display("FAIL start: got p=%0b s=%0d want p=1 s=0",
               bus.playing, bus.score);
    end
  endtask

  task automatic test_basic_hits();
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 3'b001, 3'b001);
      n_tests++;
      if (bus.score !== SW'(i) || bus.score !== SW'(m_score)) begin
        n_fail++;
        $display("FAIL basic_hit%0d: got %0d want %0d",
                 i, bus.score, i);
      end
    end
    n_tests++;
    if (bus.combo !== 4'd3) begin
      n_fail++;
      $display("FAIL basic_combo: got %0d want 3", bus.combo);
    end
  endtask

  task automatic test_double();
    step(1'b0, 1'b0, 3'b001, 3'b001);
    n_tests++;
    if (bus.doubleOn !== 1'b1 || bus.score !== 8'd4) begin
      n_fail++;
      $display("FAIL double_on: got d=%0b s=%0d want d=1 s=4",
               bus.doubleOn, bus.score);
    end
    step(1'b0, 1'b0, 3'b011, 3'b011);
    n_tests++;
    if (bus.score !== 8'd8 || bus.score !== SW'(m_score)) begin
      n_fail++;
      $display("FAIL double_pts: got %0d want 8", bus.score);
    end
  endtask

  task automatic test_clamp_low();
    step(1'b1, 1'b0, 3'b000, 3'b000);
    step(1'b0, 1'b0, 3'b100, 3'b100);
    step(1'b0, 1'b0, 3'b000, 3'b110);
    n_tests++;
    if (bus.score !== 8'd0 || bus.combo !== 4'd0) begin
      n_fail++;
      $display("FAIL clamp_low: got s=%0d c=%0d want s=0 c=0",
               bus.score, bus.combo);
    end
  endtask

  task automatic test_saturate();
    step(1'b1, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 100 && m_score <= 248; i++)
      step(1'b0, 1'b0, 3'b111, 3'b111);
    for (int i = 0; i < 10 && m_score < 254; i++)
      step(1'b0, 1'b0, 3'b111, 3'b001);
    n_tests++;
    if (bus.score !== 8'd254 || bus.doubleOn !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pre: got s=%0d d=%0b want s=254 d=1",
               bus.score, bus.doubleOn);
    end
    step(1'b0, 1'b0, 3'b111, 3'b111);
    n_tests++;
    if (bus.score !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: got %0d want 255", bus.score);
    end
  endtask

  task automatic test_hiscore();
    int want_hs;
`ifdef SCORE_TRACKER_HISCORE_EN
    want_hs = 10;
`else
    want_hs = 0;
`endif
    model_reset();
    scoreReset = 1'b1;
    #3;
    scoreReset = 1'b0;
    step(1'b1, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 20 && m_score < 10; i++)
      step(1'b0, 1'b0, 3'b001, 3'b001);
    step(1'b0, 1'b1, 3'b000, 3'b000);
    n_tests++;
    if (bus.highScore !== SW'(want_hs) || bus.playing !== 1'b0
        || bus.score !== 8'd10) begin
      n_fail++;
      $display("FAIL hiscore_end: got h=%0d p=%0b s=%0d want h=%0d p=0 s=10",
               bus.highScore, bus.playing, bus.score, want_hs);
    end
    step(1'b0, 1'b0, 3'b111, 3'b111);
    n_tests++;
    if (bus.score !== 8'd10) begin
      n_fail++;
      $display("FAIL over_frozen: got %0d want 10", bus.score);
    end
    step(1'b1, 1'b0, 3'b111, 3'b111);
    n_tests++;
    if (bus.score !== 8'd0 || bus.highScore !== SW'(want_hs)) begin
      n_fail++;
      $display("FAIL hiscore_keep: got s=%0d h=%0d want s=0 h=%0d",
               bus.score, bus.highScore, want_hs);
    end
  endtask

  task automatic test_end_hit();
    step(1'b0, 1'b0, 3'b010, 3'b010);
    step(1'b0, 1'b1, 3'b010, 3'b010);
    n_tests++;
    if (bus.score !== 8'd2 || bus.score !== SW'(m_score)) begin
      n_fail++;
      $display("FAIL end_hit: got %0d want 2", bus.score);
    end
    step(1'b1, 1'b1, 3'b000, 3'b000);
    n_tests++;
    if (bus.playing !== 1'b1 || bus.score !== 8'd0) begin
      n_fail++;
      $display("FAIL start_wins: got p=%0b s=%0d want p=1 s=0",
               bus.playing, bus.score);
    end
  endtask

  task automatic test_random();
    logic gs, ge;
    logic [N-1:0] mu, h;
    logic [SW+SW+5:0] got, exp;
    int errs;
    errs = 0;
    for (int i = 0; i < 1500; i++) begin
      gs = ($urandom_range(0, 39) == 0);
      ge = ($urandom_range(0, 29) == 0);
      mu = N'($urandom);
      h  = N'($urandom);
      if ($urandom_range(0, 3) != 0)
        h = h & mu;
      step(gs, ge, mu, h);
      got = {bus.score, bus.combo, bus.doubleOn,
             bus.playing, bus.highScore};
      exp = {SW'(m_score), 4'(m_combo), 1'(m_dbl),
             1'(m_st == ST_PLAY), SW'(m_hs)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 3'b011, 3'b011);
    #3;
    scoreReset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({bus.score, bus.combo, bus.doubleOn,
         bus.playing, bus.highScore} !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got s=%0d c=%0d d=%0b p=%0b h=%0d want all 0",
               bus.score, bus.combo, bus.doubleOn,
               bus.playing, bus.highScore);
    end
    #2;
    scoreReset = 1'b0;
    step(1'b0, 1'b0, 3'b111, 3'b111);
    n_tests++;
    if (bus.score !== 8'd0 || bus.playing !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: got s=%0d p=%0b want s=0 p=0",
               bus.score, bus.playing);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    scoreReset    = 1'b1;
    bus.gameStart = 1'b0;
    bus.gameEnd   = 1'b0;
    bus.moleUp    = '0;
    bus.hit       = '0;
    #12;
    scoreReset = 1'b0;
    #2;
    test_reset();
    test_basic_hits();
    test_double();
    test_clamp_low();
    test_saturate();
    test_hiscore();
    test_end_hit();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
